// File: rtl/sha512_round_ctrl.sv
// sha512_round_ctrl
// Sequencing controller for one SHA-512 compression. It captures the chaining
// value, runs ROUNDS rounds of the compression datapath while consuming one
// scheduled W_t word per valid/ready handshake, and then adds the working
// variables back into the hash state.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   start         begin a compression (sampled only while idle)
//   h_in[511:0]   chaining value, H0 in [511:448] .. H7 in [63:0]
//   w_data/w_valid/w_ready   message-schedule word stream
//   round_idx[6:0]           current round, addresses the external K ROM
//   k_data[63:0]             K_t returned combinationally by the ROM
//   busy          high whenever not idle
//   done          one-cycle pulse when h_out holds the new hash
//   h_out[511:0]  hash state, same word order as h_in
module sha512_round_ctrl #(
  parameter int ROUNDS = 80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] h_in,
  input  logic [63:0]  w_data,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [6:0]   round_idx,
  input  logic [63:0]  k_data,
  output logic         busy,
  output logic         done,
  output logic [511:0] h_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  state_e       state_q, state_d;
  logic [6:0]   t_q, t_d;
  logic [63:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [63:0]  a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [511:0] hash_q, hash_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         w_ready_q, w_ready_d;
  logic [63:0]  t1_s, t2_s;

  function automatic logic [63:0] big_sigma0(input logic [63:0] x);
    return {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
  endfunction

  function automatic logic [63:0] big_sigma1(input logic [63:0] x);
    return {x[13:0], x[63:14]} ^ {x[17:0], x[63:18]} ^ {x[40:0], x[63:41]};
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y,
                                     input logic [63:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y,
                                      input logic [63:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Round temporaries; only consumed on a ROUND handshake.
  always_comb begin
    t1_s = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + k_data + w_data;
    t2_s = big_sigma0(a_q) + maj(a_q, b_q, c_q);
  end

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    hash_d  = hash_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hash_d = h_in;
          {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = h_in;
          t_d     = 7'd0;
          state_d = S_ROUND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUND: begin
        if (w_valid) begin
          h_d = g_q; g_d = f_q; f_d = e_q; e_d = d_q + t1_s;
          d_d = c_q; c_d = b_q; b_d = a_q; a_d = t1_s + t2_s;
          // The index freezes on the last round so it never passes ROUNDS-1.
          if (t_q == LAST_ROUND) begin
            state_d = S_FINAL;
          end else begin
            t_d = t_q + 7'd1;
          end
        end else begin
          state_d = S_ROUND;
        end
      end
      S_FINAL: begin
        hash_d = {hash_q[511:448] + a_q, hash_q[447:384] + b_q,
                  hash_q[383:320] + c_q, hash_q[319:256] + d_q,
                  hash_q[255:192] + e_q, hash_q[191:128] + f_q,
                  hash_q[127:64]  + g_q, hash_q[63:0]    + h_q};
        state_d = S_DONE;
      end
      S_DONE: begin
        // round_idx must read 0 once back in IDLE.
        t_d     = 7'd0;
        state_d = S_IDLE;
      end
      default: begin
        t_d     = 7'd0;
        state_d = S_IDLE;
      end
    endcase

    // Flag outputs are decoded from the next state so they come straight
    // out of flops aligned with state_q.
    busy_d    = (state_d != S_IDLE);
    w_ready_d = (state_d == S_ROUND);
    done_d    = (state_d == S_DONE);
  end

  // State, working variables and hash registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= 7'd0;
      a_q <= 64'd0; b_q <= 64'd0; c_q <= 64'd0; d_q <= 64'd0;
      e_q <= 64'd0; f_q <= 64'd0; g_q <= 64'd0; h_q <= 64'd0;
      hash_q    <= 512'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      hash_q    <= hash_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
    end
  end

  assign w_ready   = w_ready_q;
  assign round_idx = t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign h_out     = hash_q;

endmodule
